// File: rtl/uart_rx_fifo_core.sv
// uart_rx_fifo_core: oversampled asynchronous receiver with 3-sample majority vote,
// 5..9 data bits, optional parity, 1 or 2 stop bits and break detect. Received words
// and their error flags are queued in a first-word-fall-through FIFO popped via
// valid/ready. The sticky overrun flag records words dropped while the FIFO was full.
module uart_rx_fifo_core #(
    parameter int DATA_W      = 9,
    parameter int OSR         = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             i_rxclk,
    input  logic                             i_rst,
    input  logic                             i_sample_tick,
    input  logic                             i_rx,
    input  logic [2:0]                       i_ucsz,
    input  logic [1:0]                       i_upm,
    input  logic                             i_usbs,
    input  logic                             i_u2x,
    input  logic                             i_ready,
    output logic                             o_valid,
    output logic [DATA_W-1:0]                o_data,
    output logic                             o_frame_error,
    output logic                             o_parity_error,
    output logic                             o_break,
    output logic                             o_data_overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_count
);

    localparam int CNT_W  = $clog2(OSR);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int WORD_W = DATA_W + 3;

    // Tick-counter landmarks for normal speed (N=OSR) and double speed (N=OSR/2).
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OSR - 1);
    localparam logic [CNT_W-1:0] FULL_V0   = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_V1   = CNT_W'(OSR / 2);
    localparam logic [CNT_W-1:0] FULL_V2   = CNT_W'(OSR / 2 + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] HALF_V0   = CNT_W'((OSR / 2) / 2 - 1);
    localparam logic [CNT_W-1:0] HALF_V1   = CNT_W'((OSR / 2) / 2);
    localparam logic [CNT_W-1:0] HALF_V2   = CNT_W'((OSR / 2) / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    // Character-size decode; reserved encodings fall back to 8 bits.
    function automatic logic [3:0] decode_nbits(input logic [2:0] ucsz);
        case (ucsz)
            3'b000:  decode_nbits = 4'd5;
            3'b001:  decode_nbits = 4'd6;
            3'b010:  decode_nbits = 4'd7;
            3'b111:  decode_nbits = 4'd9;
            default: decode_nbits = 4'd8;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q,    state_d;
    logic                   armed_q,    armed_d;
    logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [3:0]             bit_idx_q,  bit_idx_d;
    logic [3:0]             nbits_q,    nbits_d;
    logic                   par_en_q,   par_en_d;
    logic                   par_odd_q,  par_odd_d;
    logic                   two_stop_q, two_stop_d;
    logic                   u2x_q,      u2x_d;
    logic [DATA_W-1:0]      shift_q,    shift_d;
    logic                   vote0_q,    vote0_d;
    logic                   vote1_q,    vote1_d;
    logic                   par_bit_q,  par_bit_d;
    logic                   perr_q,     perr_d;
    logic                   ferr_q,     ferr_d;
    logic                   brk_q,      brk_d;

    logic                   push;
    logic [WORD_W-1:0]      push_word;

    logic                   rx_s;
    logic [CNT_W-1:0]       cnt_last, cnt_v0, cnt_v1, cnt_v2;
    logic                   voted;
    logic                   at_dec;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign cnt_last = u2x_q ? HALF_LAST : FULL_LAST;
    assign cnt_v0   = u2x_q ? HALF_V0   : FULL_V0;
    assign cnt_v1   = u2x_q ? HALF_V1   : FULL_V1;
    assign cnt_v2   = u2x_q ? HALF_V2   : FULL_V2;
    assign voted    = (vote0_q & vote1_q) | (vote0_q & rx_s) | (vote1_q & rx_s);
    assign at_dec   = i_sample_tick && (tick_cnt_q == cnt_v2);

    // RX line synchroniser, clocked every cycle; resets to the idle-high level.
    always_ff @(posedge i_rxclk) begin
        if (i_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
        end
    end

    // Receiver FSM and datapath register bank.
    always_ff @(posedge i_rxclk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            nbits_q    <= 4'd8;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            u2x_q      <= 1'b0;
            shift_q    <= '0;
            vote0_q    <= 1'b0;
            vote1_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            u2x_q      <= u2x_d;
            shift_q    <= shift_d;
            vote0_q    <= vote0_d;
            vote1_q    <= vote1_d;
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    // Next-state logic: frame sequencing, majority voting and word assembly.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        armed_d    = armed_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        u2x_d      = u2x_q;
        shift_d    = shift_q;
        vote0_d    = vote0_q;
        vote1_d    = vote1_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        push       = 1'b0;
        push_word  = '0;

        // Bit-period counter and the two early votes run in every non-idle state.
        if (i_sample_tick && (state_q != S_IDLE)) begin
            tick_cnt_d = (tick_cnt_q == cnt_last) ? '0 : tick_cnt_q + CNT_W'(1);
            if (tick_cnt_q == cnt_v0) vote0_d = rx_s;
            if (tick_cnt_q == cnt_v1) vote1_d = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                if (i_sample_tick) begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        // Falling edge after a seen-high line: latch frame format and start.
                        state_d    = S_START;
                        armed_d    = 1'b0;
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        nbits_d    = decode_nbits(i_ucsz);
                        par_en_d   = i_upm[1];
                        par_odd_d  = i_upm[0];
                        two_stop_d = i_usbs;
                        u2x_d      = i_u2x;
                        shift_d    = '0;
                        par_bit_d  = 1'b0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        brk_d      = 1'b0;
                    end
                end
            end
            S_START: begin
                if (at_dec) begin
                    state_d = voted ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (at_dec) begin
                    shift_d[bit_idx_q] = voted;
                    bit_idx_d          = bit_idx_q + 4'd1;
                    if (bit_idx_q == nbits_q - 4'd1) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end
                end
            end
            S_PARITY: begin
                if (at_dec) begin
                    par_bit_d = voted;
                    perr_d    = (voted != ((^shift_q) ^ par_odd_q));
                    state_d   = S_STOP1;
                end
            end
            S_STOP1: begin
                if (at_dec) begin
                    ferr_d = ~voted;
                    brk_d  = (shift_q == '0) && (!par_en_q || !par_bit_q) && !voted;
                    if (two_stop_q) begin
                        state_d = S_STOP2;
                    end else begin
                        push      = 1'b1;
                        push_word = {brk_d, perr_q, ferr_d, shift_q};
                        state_d   = S_IDLE;
                    end
                end
            end
            S_STOP2: begin
                if (at_dec) begin
                    ferr_d    = ferr_q | ~voted;
                    push      = 1'b1;
                    push_word = {brk_q, perr_q, ferr_d, shift_q};
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [FCNT_W-1:0] count_q,   count_d;
    logic              overrun_q, overrun_d;

    logic              full;
    logic              pop;
    logic              accept;
    logic              drop;
    logic [WORD_W-1:0] head;

    assign o_valid = (count_q != '0);
    assign full    = (count_q == FCNT_W'(FIFO_DEPTH));
    assign pop     = o_valid & i_ready;
    assign accept  = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign head    = mem_q[rd_ptr_q];

    // FIFO bookkeeping: pointers, occupancy and sticky overrun.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({accept, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overrun_d = 1'b1;
        end else if (pop) begin
            overrun_d = 1'b0;
        end
    end

    // FIFO control registers.
    always_ff @(posedge i_rxclk) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge i_rxclk) begin
        // NOTE: storage is deliberately not reset; outputs are masked by o_valid instead.
        if (accept) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign o_data         = o_valid ? head[DATA_W-1:0] : '0;
    assign o_frame_error  = o_valid & head[DATA_W];
    assign o_parity_error = o_valid & head[DATA_W+1];
    assign o_break        = o_valid & head[DATA_W+2];
    assign o_data_overrun = overrun_q;
    assign o_fifo_count   = count_q;

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// Scoreboard bench for uart_rx_fifo_core: directed frames push expected words into a
// queue; a monitor pops and compares every word the DUT hands over on valid & ready.
module tb_uart_rx_fifo_core;

    localparam int DATA_W     = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int NB         = 16;
    localparam int NH         = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic              rx;
    logic [2:0]        ucsz;
    logic [1:0]        upm;
    logic              usbs;
    logic              u2x;
    logic              ready;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ferr;
    logic              perr;
    logic              brk;
    logic              ovr;
    logic [CW-1:0]     count;

    int n_checks = 0;
    int n_errors = 0;

    // expected word: {break, parity error, frame error, data[8:0]}
    logic [11:0] exp_q [$];

    uart_rx_fifo_core #(
        .DATA_W(DATA_W), .OSR(16), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2)
    ) dut (
        .i_rxclk        (clk),
        .i_rst          (rst),
        .i_sample_tick  (tick),
        .i_rx           (rx),
        .i_ucsz         (ucsz),
        .i_upm          (upm),
        .i_usbs         (usbs),
        .i_u2x          (u2x),
        .i_ready        (ready),
        .o_valid        (valid),
        .o_data         (data),
        .o_frame_error  (ferr),
        .o_parity_error (perr),
        .o_break        (brk),
        .o_data_overrun (ovr),
        .o_fifo_count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one word is consumed per cycle with valid & ready; compare it with the queue head.
    always begin
        logic [11:0] e;
        @(negedge clk);
        #1;
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got data 0x%0h with nothing expected", data);
            end else begin
                e = exp_q.pop_front();
                check("pop_data", 32'(data), 32'(e[8:0]));
                check("pop_brk",  32'(brk),  32'(e[11]));
                check("pop_perr", 32'(perr), 32'(e[10]));
                check("pop_ferr", 32'(ferr), 32'(e[9]));
            end
        end
    end

    // Drive a frame LSB first, each bit held for n sample ticks; line returns high.
    task automatic send(input logic [15:0] bits, input int len, input int n);
        for (int i = 0; i < len; i++) begin
            rx = bits[i];
            repeat (n) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int nbits, input int n);
        rx = 1'b1;
        repeat (nbits * n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [2:0] c, input logic [1:0] p, input logic s, input logic x);
        ucsz = c;
        upm  = p;
        usbs = s;
        u2x  = x;
    endtask

    // Let the monitor consume everything, bounded in cycles.
    task automatic drain(input string name);
        int i;
        ready = 1'b1;
        i = 0;
        while (valid && i < 100) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        check(name, 32'(valid), 32'd0);
        ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        tick  = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        set_cfg(3'b011, 2'b00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data",  32'(data),  32'd0);
        check("rst_flags", 32'({brk, perr, ferr, ovr}), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        idle(2, NB);

        // 8N1 0xA5
        exp_q.push_back({1'b0, 1'b0, 1'b0, 9'h0A5});
        send({1'b1, 8'hA5, 1'b0}, 10, NB);
        idle(2, NB);
        check("a5_count", 32'(count), 32'd1);
        check("a5_valid", 32'(valid), 32'd1);
        drain("a5_drained");

        // 9-bit even parity, data 0x1FF, parity bit 0 -> parity error
        set_cfg(3'b111, 2'b10, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 9'h1FF});
        send({1'b1, 1'b0, 9'h1FF, 1'b0}, 12, NB);
        idle(2, NB);
        check("par_count", 32'(count), 32'd1);
        drain("par_drained");

        // Low glitch of 5 ticks -> false start
        set_cfg(3'b011, 2'b00, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(3, NB);
        check("glitch_count", 32'(count), 32'd0);
        check("glitch_valid", 32'(valid), 32'd0);

        // Five frames with no consumer -> four stored, overrun sticky
        for (int k = 1; k <= 5; k++) begin
            logic [7:0] d;
            d = 8'(k);
            if (k <= 4) exp_q.push_back({3'b000, 1'b0, d});
            send({1'b1, d, 1'b0}, 10, NB);
            idle(1, NB);
        end
        idle(1, NB);
        check("ovr_count", 32'(count), 32'd4);
        check("ovr_set",   32'(ovr),   32'd1);
        ready = 1'b1;
        @(negedge clk);
        #2;
        check("ovr_cleared", 32'(ovr), 32'd0);
        drain("ovr_drained");

        // Line low for 12 bit-times -> single break word, no restart while low
        exp_q.push_back({1'b1, 1'b0, 1'b1, 9'h000});
        rx = 1'b0;
        repeat (12 * NB) @(negedge clk);
        idle(3, NB);
        check("brk_count", 32'(count), 32'd1);
        drain("brk_drained");

        // Double speed 7E2, 0x55, second stop bit 0 -> frame error
        set_cfg(3'b010, 2'b10, 1'b1, 1'b1);
        exp_q.push_back({1'b0, 1'b0, 1'b1, 9'h055});
        send({5'b0, 1'b0, 1'b1, 1'b0, 7'h55, 1'b0}, 11, NH);
        idle(3, NH);
        check("u2x_count", 32'(count), 32'd1);
        drain("u2x_drained");

        // Reset mid-frame discards partial word; next frame is received
        set_cfg(3'b011, 2'b00, 1'b0, 1'b0);
        send(16'h0000, 5, NB);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2, NB);
        check("midrst_count", 32'(count), 32'd0);
        exp_q.push_back({1'b0, 1'b0, 1'b0, 9'h03C});
        send({1'b1, 8'h3C, 1'b0}, 10, NB);
        idle(2, NB);
        check("post_rst_count", 32'(count), 32'd1);
        drain("post_rst_drained");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
